layer_walker: RTL and testbench
===============================

Name: layer_walker

Overview:
- Parametrised successor to the pipe-0 layer counter in the pixel-counter stage.
- Walks one pixel through its enabled layers in ascending order and presents one layer index at a time to the next pipeline stage; `layer_inc` advances the walk.
- Fully synchronous single-clock design. Adds a runtime layer-enable mask with skipping, a programmable walk length, a 1-cycle done pulse, and a start/busy handshake.

Parameters:
- LAYER_W, 5, width of the layer index.
- NUM_LAYERS, 32, number of physical layers; must satisfy 1 <= NUM_LAYERS <= 2**LAYER_W.
- SKIP_DISABLED, 1, 1 = skip layers whose enable bit is 0; 0 = ignore the mask and walk 0..NUM_LAYERS-1.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a walk for a new pixel; honoured only when busy=0.
- layer_en  in  NUM_LAYERS  per-layer enable mask; sampled only on an accepted start.
- layer_inc  in  1  consumer accepted the current layer; advance.
- layer  out  LAYER_W  current layer index.
- layer_valid  out  1  layer is meaningful.
- last  out  1  current layer is the final one of this walk.
- done  out  1  1-cycle pulse: walk finished.
- busy  out  1  a walk is in progress.
- start_err  out  1  1-cycle pulse: start arrived while busy=1.

Behaviour:
- Reset (reset=1 at an edge) overrides every other input.
  - Outputs clear: layer=0, layer_valid=0, last=0, done=0, busy=0, start_err=0.
  - Mask snapshot clears to 0; state goes to IDLE.
- States: IDLE, ACTIVE.
- IDLE:
  - layer=0 and layer_valid=0; layer_inc is ignored.
  - On start, snapshot layer_en into an internal register. With SKIP_DISABLED=0 the snapshot is all-ones.
  - Snapshot == 0: done=1 on the next cycle, stay in IDLE, layer_valid stays 0.
  - Otherwise go to ACTIVE on the next cycle with layer = lowest set index, layer_valid=1, busy=1. Start-to-valid latency is 1 cycle.
- ACTIVE:
  - layer_valid=1 and busy=1.
  - last is combinational: high when the snapshot has no set bit above the current layer.
  - layer_inc with last=0: layer advances on the next edge to the next higher set index; disabled layers are skipped within that single cycle.
  - layer_inc with last=1: next cycle done=1, layer=0, layer_valid=0, busy=0, state IDLE.
  - Without layer_inc: layer holds indefinitely.
- start while busy=1:
  - Ignored: snapshot and walk are unaffected.
  - start_err pulses on the next cycle.
- start in the same cycle as the final layer_inc is still ignored, because busy=1 during that cycle.
  - start_err pulses.
  - The upstream block must re-issue start once busy=0.
- Changes to layer_en during a walk have no effect; only the snapshot is used.
- Indices at or above NUM_LAYERS are never produced.
- SKIP_DISABLED=0:
  - The sequence is 0,1,...,NUM_LAYERS-1.
  - done is the equivalent of the legacy overflow flag, occurring after the last layer is accepted.
- reset=1 in ACTIVE aborts the walk with no done pulse.
- done and start_err are never high for more than one consecutive cycle.

Decomposition:
- Shared package gpu_layer_pkg holds:
  - LAYER_W and NUM_LAYERS defaults;
  - the state enum {IDLE, ACTIVE};
  - the layer index typedef.
- Sub-module layer_next_enc: combinational.
  - Inputs: mask and current index.
  - Outputs: next set index strictly above the current index, a found flag, and the lowest set index.
  - Instantiated once.

Test Plan:
- Reset with all inputs toggling → after one edge, all outputs 0; layer_inc in IDLE leaves layer=0 and layer_valid=0.
- layer_en=0x0000_0015, start, then layer_inc every cycle → layer = 0, 2, 4; last=1 only at 4; done pulses once on the cycle after the third layer_inc; busy then 0.
- layer_en=0x8000_0000, start → layer=31 with last=1 immediately; one layer_inc → done, layer=0.
- layer_en=0, start → done=1 one cycle later; layer_valid never asserted.
- Mid-walk, mask 0x0F → 0xF0 plus an extra start → walk stays 0,1,2,3; start_err pulses once; a re-issued start after done walks 4..7.
- SKIP_DISABLED=0, NUM_LAYERS=8, layer_en=0 → walk 0..7, done after the 8th layer_inc; reset asserted at layer=5 → layer=0, no done.

Source files
------------

// File: rtl/gpu_layer_pkg.sv
// Shared types and defaults for the per-pixel layer walker.
// Holds the walk state encoding and the default layer index shape.
package gpu_layer_pkg;

    localparam int LAYER_W_DEF    = 5;
    localparam int NUM_LAYERS_DEF = 32;

    typedef logic [LAYER_W_DEF-1:0] layer_idx_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } walk_state_e;

endpackage

// File: rtl/layer_next_enc.sv
// Set-bit search over a layer mask: the next set index strictly
// above the current one, whether it exists, and the lowest set index.
module layer_next_enc
    import gpu_layer_pkg::*;
#(
    parameter int LAYER_W    = LAYER_W_DEF,
    parameter int NUM_LAYERS = NUM_LAYERS_DEF
) (
    input  logic [NUM_LAYERS-1:0] mask_i,
    input  logic [LAYER_W-1:0]    cur_i,
    output logic [LAYER_W-1:0]    next_o,
    output logic                  found_o,
    output logic [LAYER_W-1:0]    low_o
);

    // Scan high to low so the last hit seen is the lowest qualifying bit.
    always_comb begin
        next_o  = '0;
        found_o = 1'b0;
        low_o   = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                low_o = LAYER_W'(i);
                if (LAYER_W'(i) > cur_i) begin
                    next_o  = LAYER_W'(i);
                    found_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/layer_walker.sv
// Walks one pixel through its enabled layers in ascending order,
// presenting one index at a time with a start/busy/done handshake.
module layer_walker
    import gpu_layer_pkg::*;
#(
    parameter int LAYER_W       = LAYER_W_DEF,
    parameter int NUM_LAYERS    = NUM_LAYERS_DEF,
    parameter bit SKIP_DISABLED = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NUM_LAYERS-1:0] layer_en,
    input  logic                  layer_inc,
    output logic [LAYER_W-1:0]    layer,
    output logic                  layer_valid,
    output logic                  last,
    output logic                  done,
    output logic                  busy,
    output logic                  start_err
);

    walk_state_e           state_q;
    logic [NUM_LAYERS-1:0] mask_q;
    logic [LAYER_W-1:0]    layer_q;
    logic                  valid_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;

    logic [NUM_LAYERS-1:0] start_mask_d;
    logic [NUM_LAYERS-1:0] enc_mask_d;
    logic [LAYER_W-1:0]    next_d;
    logic [LAYER_W-1:0]    low_d;
    logic                  found_d;

    // Candidate snapshot; while idle the encoder looks at it to find the first layer.
    always_comb begin
        start_mask_d = SKIP_DISABLED ? layer_en : '1;
        enc_mask_d   = (state_q == IDLE) ? start_mask_d : mask_q;
    end

    layer_next_enc #(
        .LAYER_W    (LAYER_W),
        .NUM_LAYERS (NUM_LAYERS)
    ) u_enc (
        .mask_i  (enc_mask_d),
        .cur_i   (layer_q),
        .next_o  (next_d),
        .found_o (found_d),
        .low_o   (low_d)
    );

    // Walk FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            layer_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        mask_q <= start_mask_d;
                        if (start_mask_d == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= ACTIVE;
                            layer_q <= low_d;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (start) begin
                        err_q <= 1'b1;
                    end
                    if (layer_inc) begin
                        if (found_d) begin
                            layer_q <= next_d;
                        end else begin
                            state_q <= IDLE;
                            layer_q <= '0;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Final layer of the walk: no enabled layer above the current one.
    always_comb begin
        last = (state_q == ACTIVE) && !found_d;
    end

    assign layer       = layer_q;
    assign layer_valid = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign start_err   = err_q;

endmodule

// File: tb/tb_layer_walker.sv
// Bench for layer_walker: a queue model of the enabled-layer walk
// checked every cycle, plus directed literal expectations.
module tb_layer_walker;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 32 layers, mask skipping on
    logic        rst_a, start_a, inc_a;
    logic [31:0] en_a;
    logic [4:0]  layer_a;
    logic        valid_a, last_a, done_a, busy_a, err_a;

    // Instance B: 8 layers, mask ignored
    logic        rst_b, start_b, inc_b;
    logic [7:0]  en_b;
    logic [2:0]  layer_b;
    logic        valid_b, last_b, done_b, busy_b, err_b;

    layer_walker #(
        .LAYER_W(5), .NUM_LAYERS(32), .SKIP_DISABLED(1'b1)
    ) dut_a (
        .clk(clk), .reset(rst_a), .start(start_a), .layer_en(en_a),
        .layer_inc(inc_a), .layer(layer_a), .layer_valid(valid_a),
        .last(last_a), .done(done_a), .busy(busy_a), .start_err(err_a)
    );

    layer_walker #(
        .LAYER_W(3), .NUM_LAYERS(8), .SKIP_DISABLED(1'b0)
    ) dut_b (
        .clk(clk), .reset(rst_b), .start(start_b), .layer_en(en_b),
        .layer_inc(inc_b), .layer(layer_b), .layer_valid(valid_b),
        .last(last_b), .done(done_b), .busy(busy_b), .start_err(err_b)
    );

    int checks = 0;
    int errors = 0;

    // Model: remaining layers of the walk as a queue per instance.
    int q [2][$];
    bit m_done [2];
    bit m_err  [2];
    bit armed = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input bit r, input bit s,
                              input bit inc, input logic [31:0] en,
                              input bit skip, input int n);
        if (r) begin
            q[k].delete();
            m_done[k] = 1'b0;
            m_err[k]  = 1'b0;
        end else begin
            m_done[k] = 1'b0;
            m_err[k]  = 1'b0;
            if (q[k].size() > 0) begin
                if (s) m_err[k] = 1'b1;
                if (inc) begin
                    void'(q[k].pop_front());
                    if (q[k].size() == 0) m_done[k] = 1'b1;
                end
            end else if (s) begin
                for (int i = 0; i < n; i++)
                    if (!skip || en[i]) q[k].push_back(i);
                if (q[k].size() == 0) m_done[k] = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, rst_a, start_a, inc_a, en_a, 1'b1, 32);
        model_step(1, rst_b, start_b, inc_b, {24'd0, en_b}, 1'b0, 8);
        armed = 1'b1;
    end

    function automatic int exp_layer(input int k);
        return (q[k].size() > 0) ? q[k][0] : 0;
    endfunction

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("a.layer", int'(layer_a), exp_layer(0));
            chk("a.valid", int'(valid_a), int'(q[0].size() > 0));
            chk("a.busy",  int'(busy_a),  int'(q[0].size() > 0));
            chk("a.last",  int'(last_a),  int'(q[0].size() == 1));
            chk("a.done",  int'(done_a),  int'(m_done[0]));
            chk("a.err",   int'(err_a),   int'(m_err[0]));
            chk("b.layer", int'(layer_b), exp_layer(1));
            chk("b.valid", int'(valid_b), int'(q[1].size() > 0));
            chk("b.busy",  int'(busy_b),  int'(q[1].size() > 0));
            chk("b.last",  int'(last_b),  int'(q[1].size() == 1));
            chk("b.done",  int'(done_b),  int'(m_done[1]));
            chk("b.err",   int'(err_b),   int'(m_err[1]));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        start_a = 1'b1; start_b = 1'b1;
        inc_a = 1'b1; inc_b = 1'b1;
        en_a = 32'hFFFF_FFFF; en_b = 8'hFF;
        step();
        en_a = 32'h5555_0000; en_b = 8'h0F; start_a = 1'b0;
        step();
        chk("lit.rst.layer", int'(layer_a), 0);
        chk("lit.rst.valid", int'(valid_a), 0);
        chk("lit.rst.busy",  int'(busy_b), 0);
        rst_a = 1'b0; rst_b = 1'b0;
        start_a = 1'b0; start_b = 1'b0; inc_a = 1'b1; inc_b = 1'b1;
        step();
        chk("lit.idle_inc.layer", int'(layer_a), 0);
        chk("lit.idle_inc.valid", int'(valid_a), 0);
        inc_a = 1'b0; inc_b = 1'b0;

        // 0x15: layers 0, 2, 4
        en_a = 32'h0000_0015; start_a = 1'b1;
        step();
        chk("lit.w15.l0", int'(layer_a), 0);
        chk("lit.w15.last0", int'(last_a), 0);
        start_a = 1'b0; inc_a = 1'b1;
        step();
        chk("lit.w15.l2", int'(layer_a), 2);
        step();
        chk("lit.w15.l4", int'(layer_a), 4);
        chk("lit.w15.last4", int'(last_a), 1);
        step();
        chk("lit.w15.done", int'(done_a), 1);
        chk("lit.w15.busy", int'(busy_a), 0);
        inc_a = 1'b0;
        step();
        chk("lit.w15.done_pulse", int'(done_a), 0);

        // Top layer only
        en_a = 32'h8000_0000; start_a = 1'b1;
        step();
        chk("lit.top.l31", int'(layer_a), 31);
        chk("lit.top.last", int'(last_a), 1);
        start_a = 1'b0; inc_a = 1'b1;
        step();
        chk("lit.top.done", int'(done_a), 1);
        chk("lit.top.layer", int'(layer_a), 0);
        inc_a = 1'b0;

        // Empty mask
        en_a = 32'h0; start_a = 1'b1;
        step();
        chk("lit.empty.done", int'(done_a), 1);
        chk("lit.empty.valid", int'(valid_a), 0);
        start_a = 1'b0;
        step();
        chk("lit.empty.done_pulse", int'(done_a), 0);

        // Mask change and extra start mid-walk
        en_a = 32'h0F; start_a = 1'b1;
        step();
        chk("lit.mid.l0", int'(layer_a), 0);
        en_a = 32'hF0; start_a = 1'b1; inc_a = 1'b1;
        step();
        chk("lit.mid.l1", int'(layer_a), 1);
        chk("lit.mid.err", int'(err_a), 1);
        start_a = 1'b0;
        step();
        chk("lit.mid.l2", int'(layer_a), 2);
        chk("lit.mid.err_pulse", int'(err_a), 0);
        step();
        chk("lit.mid.l3", int'(layer_a), 3);
        step();
        chk("lit.mid.done", int'(done_a), 1);
        inc_a = 1'b0; start_a = 1'b1;
        step();
        chk("lit.mid.re_l4", int'(layer_a), 4);
        start_a = 1'b0; inc_a = 1'b1;
        repeat (3) step();
        chk("lit.mid.re_l7", int'(layer_a), 7);
        step();
        chk("lit.mid.re_done", int'(done_a), 1);
        inc_a = 1'b0;

        // Start coinciding with the final layer_inc is rejected
        en_a = 32'h3; start_a = 1'b1;
        step();
        start_a = 1'b0; inc_a = 1'b1;
        step();
        chk("lit.race.last", int'(last_a), 1);
        start_a = 1'b1;
        step();
        chk("lit.race.done", int'(done_a), 1);
        chk("lit.race.err", int'(err_a), 1);
        start_a = 1'b0; inc_a = 1'b0;
        step();
        chk("lit.race.busy", int'(busy_a), 0);

        // Instance B: mask ignored, full 0..7 walk
        en_b = 8'h00; start_b = 1'b1;
        step();
        chk("lit.b.l0", int'(layer_b), 0);
        start_b = 1'b0; inc_b = 1'b1;
        for (int i = 1; i < 8; i++) begin
            step();
            chk("lit.b.seq", int'(layer_b), i);
        end
        chk("lit.b.last7", int'(last_b), 1);
        step();
        chk("lit.b.done", int'(done_b), 1);
        inc_b = 1'b0; start_b = 1'b1;
        step();
        start_b = 1'b0; inc_b = 1'b1;
        repeat (5) step();
        chk("lit.b.l5", int'(layer_b), 5);
        rst_b = 1'b1; inc_b = 1'b0;
        step();
        chk("lit.b.abort_layer", int'(layer_b), 0);
        chk("lit.b.abort_done", int'(done_b), 0);
        rst_b = 1'b0;
        step();
        chk("lit.b.abort_done2", int'(done_b), 0);
        chk("lit.b.abort_valid", int'(valid_b), 0);

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
